pico_ctrl_fsm: RTL and testbench

//  Instruction sequencer for the picoMIPS core. Owns the program counter and

---
 rtl/pico_ctrl_fsm_if.sv | 30 +++
 rtl/pico_ctrl_fsm.sv | 147 ++++++++++++++
 tb/tb_pico_ctrl_fsm.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pico_ctrl_fsm_if.sv
// picoMIPS sequencer bundle: program-memory, decoder and input-switch signals.
// The slave side is the sequencer; the master side drives it.
interface pico_ctrl_fsm_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
);
   logic             start;
   logic [2:0]       opcode;
   logic             dec_write;
   logic             in_valid;
   logic [PC_W-1:0]  pc;
   logic             reg_we;
   logic             in_ack;
   logic             busy;
   logic             done;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      output start, opcode, dec_write, in_valid,
      input  pc, reg_we, in_ack, busy, done,
      input  illegal, retired
   );

   modport slave (
      input  start, opcode, dec_write, in_valid,
      output pc, reg_we, in_ack, busy, done,
      output illegal, retired
   );
endinterface

// File: rtl/pico_ctrl_fsm.sv
// picoMIPS instruction sequencer: owns pc, gates register writes,
// stalls LOAD on the external input and waits for its release.
module pico_ctrl_fsm #(
   parameter int PC_W    = 8,
   parameter int PC_LAST = 255,
   parameter int LOOP    = 0,
   parameter int CNT_W   = 16
) (
   input logic            clk,
   input logic            nReset,
   pico_ctrl_fsm_if.slave bus
);
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_MULI = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [2:0] OP_LOAD = 3'b100;

   localparam logic [PC_W-1:0] LAST = PC_W'(PC_LAST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_WAIT,
      S_REL,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic             fin_q, fin_d;

   logic is_load, legal, at_last, end_hit;
   logic retire, ack, ill, restart;

   always_comb begin
      is_load = 1'b0;
      legal   = 1'b0;
      unique case (bus.opcode)
         OP_NOP, OP_MULI, OP_ADD, OP_ADDI: legal = 1'b1;
         OP_LOAD: begin
            legal   = 1'b1;
            is_load = 1'b1;
         end
         default: ;
      endcase
   end

   assign at_last = (pc_q == LAST);
   assign end_hit = at_last && (LOOP == 0);
   assign restart = bus.start &&
                    (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ret_q   <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ret_q   <= ret_d;
         fin_q   <= fin_d;
      end
   end

   // fin_q remembers a final LOAD so RELEASE exits to DONE, not RUN
   always_comb begin
      state_d = state_q;
      fin_d   = fin_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               fin_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (is_load)
               state_d = bus.in_valid ? S_REL : S_WAIT;
            else if (end_hit)
               state_d = S_DONE;
         end
         S_WAIT: begin
            if (bus.in_valid)
               state_d = S_REL;
         end
         S_REL: begin
            if (!bus.in_valid)
               state_d = fin_q ? S_DONE : S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
      if (ack && end_hit)
         fin_d = 1'b1;
   end

   always_comb begin
      retire = 1'b0;
      ack    = 1'b0;
      ill    = 1'b0;
      case (state_q)
         S_RUN: begin
            if (is_load) begin
               retire = bus.in_valid;
               ack    = bus.in_valid;
            end else begin
               retire = 1'b1;
               ill    = !legal;
            end
         end
         S_WAIT: begin
            retire = bus.in_valid;
            ack    = bus.in_valid;
         end
         default: ;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      ret_d = ret_q;
      if (restart) begin
         pc_d  = '0;
         ret_d = '0;
      end else if (retire) begin
         if (ret_q != '1)
            ret_d = ret_q + 1'b1;
         if (!at_last)
            pc_d = pc_q + 1'b1;
         else if (LOOP != 0)
            pc_d = '0;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.retired = ret_q;
   assign bus.reg_we  = retire & bus.dec_write & ~ill;
   assign bus.in_ack  = ack;
   assign bus.illegal = ill;
   assign bus.busy    = (state_q == S_RUN) ||
                        (state_q == S_WAIT) ||
                        (state_q == S_REL);
   assign bus.done    = (state_q == S_DONE);
endmodule

// File: tb/tb_pico_ctrl_fsm.sv
// Bench for pico_ctrl_fsm: three parameter sets share one stimulus stream
// and are compared every cycle against a behavioural model.
module tb_pico_ctrl_fsm;
   localparam int N = 3;
   localparam int PH_IDLE = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_WAIT = 2;
   localparam int PH_REL  = 3;
   localparam int PH_DONE = 4;

   logic       clk = 1'b0;
   logic       nReset;
   logic       start, dec_write, in_valid;
   logic [2:0] opcode;

   logic [15:0] o_pc[N];
   logic [15:0] o_ret[N];
   logic        o_we[N], o_ack[N], o_ill[N];
   logic        o_busy[N], o_done[N];

   int m_last[N] = '{3, 1, 9};
   int m_loop[N] = '{0, 1, 0};
   int m_cmax[N] = '{65535, 15, 255};
   int m_ph[N], m_pc[N], m_ret[N];
   bit m_fin[N];
   int n_we[N], n_ack[N], n_ill[N];

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pico_ctrl_fsm_if #(.PC_W(4), .CNT_W(16)) bus_a ();
   pico_ctrl_fsm_if #(.PC_W(4), .CNT_W(4))  bus_b ();
   pico_ctrl_fsm_if #(.PC_W(8), .CNT_W(8))  bus_c ();

   assign bus_a.start = start;
   assign bus_a.opcode = opcode;
   assign bus_a.dec_write = dec_write;
   assign bus_a.in_valid = in_valid;
   assign bus_b.start = start;
   assign bus_b.opcode = opcode;
   assign bus_b.dec_write = dec_write;
   assign bus_b.in_valid = in_valid;
   assign bus_c.start = start;
   assign bus_c.opcode = opcode;
   assign bus_c.dec_write = dec_write;
   assign bus_c.in_valid = in_valid;

   assign o_pc[0] = 16'(bus_a.pc);
   assign o_pc[1] = 16'(bus_b.pc);
   assign o_pc[2] = 16'(bus_c.pc);
   assign o_ret[0] = 16'(bus_a.retired);
   assign o_ret[1] = 16'(bus_b.retired);
   assign o_ret[2] = 16'(bus_c.retired);
   assign o_we[0] = bus_a.reg_we;
   assign o_we[1] = bus_b.reg_we;
   assign o_we[2] = bus_c.reg_we;
   assign o_ack[0] = bus_a.in_ack;
   assign o_ack[1] = bus_b.in_ack;
   assign o_ack[2] = bus_c.in_ack;
   assign o_ill[0] = bus_a.illegal;
   assign o_ill[1] = bus_b.illegal;
   assign o_ill[2] = bus_c.illegal;
   assign o_busy[0] = bus_a.busy;
   assign o_busy[1] = bus_b.busy;
   assign o_busy[2] = bus_c.busy;
   assign o_done[0] = bus_a.done;
   assign o_done[1] = bus_b.done;
   assign o_done[2] = bus_c.done;

   pico_ctrl_fsm #(.PC_W(4), .PC_LAST(3), .LOOP(0), .CNT_W(16)) u_a (
      .clk(clk), .nReset(nReset), .bus(bus_a)
   );
   pico_ctrl_fsm #(.PC_W(4), .PC_LAST(1), .LOOP(1), .CNT_W(4)) u_b (
      .clk(clk), .nReset(nReset), .bus(bus_b)
   );
   pico_ctrl_fsm #(.PC_W(8), .PC_LAST(9), .LOOP(0), .CNT_W(8)) u_c (
      .clk(clk), .nReset(nReset), .bus(bus_c)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_ph[k] = PH_IDLE;
         m_pc[k] = 0;
         m_ret[k] = 0;
         m_fin[k] = 1'b0;
      end
   endtask

   task automatic clr_counts();
      for (int k = 0; k < N; k++) begin
         n_we[k] = 0;
         n_ack[k] = 0;
         n_ill[k] = 0;
      end
   endtask

   task automatic drive(input logic s, input logic [2:0] op,
                        input logic dw, input logic iv);
      start = s;
      opcode = op;
      dec_write = dw;
      in_valid = iv;
   endtask

   // One clock: check every DUT against the model, then advance the model.
   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         bit rt, ack, ill, we, ld, legal;
         int nph;
         rt = 0; ack = 0; ill = 0;
         nph = m_ph[k];
         ld = (opcode == 3'd4);
         legal = (opcode <= 3'd4);
         case (m_ph[k])
            PH_RUN: begin
               if (ld) begin
                  if (in_valid) begin rt = 1; ack = 1; nph = PH_REL; end
                  else nph = PH_WAIT;
               end else begin
                  rt = 1;
                  ill = !legal;
               end
            end
            PH_WAIT: if (in_valid) begin rt = 1; ack = 1; nph = PH_REL; end
            PH_REL: if (!in_valid) nph = m_fin[k] ? PH_DONE : PH_RUN;
            default: if (start) nph = PH_RUN;
         endcase
         we = rt && dec_write && !ill;
         chk($sformatf("pc%0d", k), 32'(o_pc[k]), 32'(m_pc[k]));
         chk($sformatf("retired%0d", k), 32'(o_ret[k]), 32'(m_ret[k]));
         chk($sformatf("busy%0d", k), 32'(o_busy[k]),
             32'(m_ph[k] == PH_RUN || m_ph[k] == PH_WAIT ||
                 m_ph[k] == PH_REL));
         chk($sformatf("done%0d", k), 32'(o_done[k]),
             32'(m_ph[k] == PH_DONE));
         chk($sformatf("reg_we%0d", k), 32'(o_we[k]), 32'(we));
         chk($sformatf("in_ack%0d", k), 32'(o_ack[k]), 32'(ack));
         chk($sformatf("illegal%0d", k), 32'(o_ill[k]), 32'(ill));
         n_we[k] += int'(o_we[k] === 1'b1);
         n_ack[k] += int'(o_ack[k] === 1'b1);
         n_ill[k] += int'(o_ill[k] === 1'b1);
         if ((m_ph[k] == PH_IDLE || m_ph[k] == PH_DONE) && start) begin
            m_pc[k] = 0;
            m_ret[k] = 0;
            m_fin[k] = 1'b0;
         end
         if (rt) begin
            if (m_ret[k] < m_cmax[k]) m_ret[k]++;
            if (m_pc[k] < m_last[k]) m_pc[k]++;
            else if (m_loop[k] != 0) m_pc[k] = 0;
            else if (nph == PH_REL) m_fin[k] = 1'b1;
            else nph = PH_DONE;
         end
         m_ph[k] = nph;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      drive(0, 3'd0, 0, 0);
      nReset = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      nReset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      nReset = 1'b0;
      drive(0, 3'd0, 0, 0);
      model_reset();
      clr_counts();
      #2;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("rst_pc%0d", k), 32'(o_pc[k]), 0);
         chk($sformatf("rst_busy%0d", k), 32'(o_busy[k]), 0);
         chk($sformatf("rst_done%0d", k), 32'(o_done[k]), 0);
         chk($sformatf("rst_ret%0d", k), 32'(o_ret[k]), 0);
         chk($sformatf("rst_we%0d", k), 32'(o_we[k]), 0);
      end
      @(negedge clk);
      nReset = 1'b1;
      @(posedge clk);
      #1;

      // ADD x4 on PC_LAST=3, no loop
      drive(1, 3'b010, 1, 0);
      cycle();
      clr_counts();
      drive(0, 3'b010, 1, 0);
      repeat (4) cycle();
      cycle();
      chk("t2_done", 32'(o_done[0]), 1);
      chk("t2_retired", 32'(o_ret[0]), 4);
      chk("t2_we_count", 32'(n_we[0]), 4);
      chk("t2_pc", 32'(o_pc[0]), 3);

      // LOAD at pc=1 with 3 stall cycles
      pulse_reset();
      drive(1, 3'b000, 0, 0);
      cycle();
      drive(0, 3'b000, 1, 0);
      cycle();
      clr_counts();
      drive(0, 3'b100, 1, 0);
      repeat (3) begin
         cycle();
         chk("t3_hold_pc", 32'(o_pc[2]), 1);
      end
      drive(0, 3'b100, 1, 1);
      cycle();
      chk("t3_ack_count", 32'(n_ack[2]), 1);
      chk("t3_we_count", 32'(n_we[2]), 1);
      drive(0, 3'b100, 1, 0);
      cycle();
      chk("t3_pc", 32'(o_pc[2]), 2);

      // back-to-back LOADs, in_valid held for 5 cycles
      clr_counts();
      drive(0, 3'b100, 1, 1);
      repeat (5) cycle();
      chk("t4_busy_release", 32'(o_busy[2]), 1);
      drive(0, 3'b100, 1, 0);
      repeat (3) cycle();
      chk("t4_ack_one", 32'(n_ack[2]), 1);
      drive(0, 3'b100, 1, 1);
      cycle();
      drive(0, 3'b100, 1, 0);
      cycle();
      chk("t4_ack_count", 32'(n_ack[2]), 2);
      chk("t4_pc", 32'(o_pc[2]), 4);

      // illegal opcode at pc=2
      pulse_reset();
      drive(1, 3'b000, 0, 0);
      cycle();
      drive(0, 3'b000, 1, 0);
      repeat (2) cycle();
      clr_counts();
      drive(0, 3'b111, 1, 0);
      cycle();
      chk("t5_ill_count", 32'(n_ill[2]), 1);
      chk("t5_we_count", 32'(n_we[2]), 0);
      chk("t5_pc", 32'(o_pc[2]), 3);

      // looping program, retired saturates
      pulse_reset();
      drive(1, 3'b010, 1, 0);
      cycle();
      drive(0, 3'b010, 1, 0);
      repeat (20) cycle();
      chk("t6_done", 32'(o_done[1]), 0);
      chk("t6_retired", 32'(o_ret[1]), 15);

      // async reset mid-run at pc=5
      pulse_reset();
      drive(1, 3'b010, 1, 0);
      cycle();
      drive(0, 3'b010, 1, 0);
      repeat (5) cycle();
      chk("t1_pc_before", 32'(o_pc[2]), 5);
      #2;
      nReset = 1'b0;
      #1;
      chk("t1_pc", 32'(o_pc[2]), 0);
      chk("t1_busy", 32'(o_busy[2]), 0);
      chk("t1_retired", 32'(o_ret[2]), 0);
      model_reset();
      drive(0, 3'd0, 0, 0);
      @(negedge clk);
      nReset = 1'b1;
      @(posedge clk);
      #1;

      // randomized run
      for (int i = 0; i < 600; i++) begin
         logic iv;
         iv = in_valid;
         if ($urandom_range(0, 2) == 0) iv = ~iv;
         drive(logic'($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)),
               logic'($urandom_range(0, 1)), iv);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
